// File: rtl/car_motion_fsm.sv
// Car motion and door controller. Takes the head-of-queue target level,
// moves the car one floor every TRAVEL_TICKS cycles, then runs a timed
// door open/close sequence. A one-cycle arrive pulse requests a queue pop.
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | car parked, doors shut, waiting for a valid target
// S_MOVE       | travelling one floor per TRAVEL_TICKS toward tgt
// S_DOOR_OPEN  | doors open; dwell restarts while door_hold is high
// S_DOOR_CLOSE | doors closing; door_hold reopens without a new arrive
module car_motion_fsm #(
    parameter int LEVELS       = 4,
    parameter int LVL_W        = 2,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 6,
    parameter int CLOSE_TICKS  = 2
) (
    input  logic             clk_divided,
    input  logic             rst,
    input  logic             target_valid,
    input  logic [LVL_W-1:0] target_lvl,
    input  logic             door_hold,
    output logic [LVL_W-1:0] pos_lvl,
    output logic             moving,
    output logic             dir_up,
    output logic             door_open,
    output logic             door_closing,
    output logic             arrive,
    output logic             busy
);

    localparam int MAX_A     = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int MAX_TICKS = (MAX_A > CLOSE_TICKS) ? MAX_A : CLOSE_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] CLOSE_LOAD  = CNT_W'(CLOSE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE     = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_MOVE       = 2'd1,
        S_DOOR_OPEN  = 2'd2,
        S_DOOR_CLOSE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [LVL_W-1:0] pos;
    logic [LVL_W-1:0] pos_nxt;
    logic [LVL_W-1:0] tgt;
    logic [LVL_W-1:0] tgt_nxt;
    logic [LVL_W-1:0] step_lvl;
    logic             dir;
    logic             dir_nxt;
    logic             arrive_q;
    logic             arrive_nxt;
    logic [31:0]      target_ext;
    logic [31:0]      pos_ext;

    // State, counter, position and latched-target registers; rst wins over everything.
    always_ff @(posedge clk_divided) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= CNT_ZERO;
            pos      <= LVL_ZERO;
            tgt      <= LVL_ZERO;
            dir      <= 1'b0;
            arrive_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pos      <= pos_nxt;
            tgt      <= tgt_nxt;
            dir      <= dir_nxt;
            arrive_q <= arrive_nxt;
        end
    end

    // Next-state, tick counter and floor stepping; arrive is a registered pulse
    // raised only on entry to DOOR_OPEN from IDLE or MOVE.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pos_nxt    = pos;
        tgt_nxt    = tgt;
        dir_nxt    = dir;
        arrive_nxt = 1'b0;
        target_ext = 32'(target_lvl);
        pos_ext    = 32'(pos);

        // Clamp keeps the car inside 0..LEVELS-1 even if tgt were unreachable.
        step_lvl = pos;
        if (dir && (pos_ext < 32'(LEVELS - 1))) begin
            step_lvl = pos + LVL_ONE;
        end else if (!dir && (pos != LVL_ZERO)) begin
            step_lvl = pos - LVL_ONE;
        end

        case (state)
            S_IDLE: begin
                if (target_valid && (target_ext < 32'(LEVELS))) begin
                    if (target_lvl == pos) begin
                        state_nxt  = S_DOOR_OPEN;
                        cnt_nxt    = DOOR_LOAD;
                        arrive_nxt = 1'b1;
                    end else begin
                        tgt_nxt   = target_lvl;
                        dir_nxt   = (target_lvl > pos);
                        cnt_nxt   = TRAVEL_LOAD;
                        state_nxt = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                if (cnt == CNT_ZERO) begin
                    pos_nxt = step_lvl;
                    if (step_lvl == tgt) begin
                        state_nxt  = S_DOOR_OPEN;
                        cnt_nxt    = DOOR_LOAD;
                        arrive_nxt = 1'b1;
                    end else begin
                        cnt_nxt = TRAVEL_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_DOOR_OPEN: begin
                if (door_hold) begin
                    cnt_nxt = DOOR_LOAD;
                end else if (cnt == CNT_ZERO) begin
                    state_nxt = S_DOOR_CLOSE;
                    cnt_nxt   = CLOSE_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_DOOR_CLOSE: begin
                if (door_hold) begin
                    state_nxt = S_DOOR_OPEN;
                    cnt_nxt   = DOOR_LOAD;
                end else if (cnt == CNT_ZERO) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign pos_lvl      = pos;
    assign dir_up       = dir;
    assign arrive       = arrive_q;
    assign moving       = (state == S_MOVE);
    assign door_open    = (state == S_DOOR_OPEN);
    assign door_closing = (state == S_DOOR_CLOSE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_car_motion_fsm.sv
// Bench for car_motion_fsm: directed scenarios followed by random traffic,
// every cycle compared against a time-based reference of the car's journey.
module tb_car_motion_fsm;

    localparam int LEVELS = 4;
    localparam int LVL_W  = 2;
    localparam int T      = 4;
    localparam int D      = 6;
    localparam int C      = 2;

    logic             clk_divided;
    logic             rst;
    logic             target_valid;
    logic [LVL_W-1:0] target_lvl;
    logic             door_hold;
    logic [LVL_W-1:0] pos_lvl;
    logic             moving;
    logic             dir_up;
    logic             door_open;
    logic             door_closing;
    logic             arrive;
    logic             busy;

    car_motion_fsm #(
        .LEVELS(LEVELS), .LVL_W(LVL_W), .TRAVEL_TICKS(T),
        .DOOR_TICKS(D), .CLOSE_TICKS(C)
    ) dut (
        .clk_divided (clk_divided),
        .rst         (rst),
        .target_valid(target_valid),
        .target_lvl  (target_lvl),
        .door_hold   (door_hold),
        .pos_lvl     (pos_lvl),
        .moving      (moving),
        .dir_up      (dir_up),
        .door_open   (door_open),
        .door_closing(door_closing),
        .arrive      (arrive),
        .busy        (busy)
    );

    initial clk_divided = 1'b0;
    always #5 clk_divided = ~clk_divided;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: a journey is a start floor plus elapsed time; doors are
    // described by how many cycles of open / closing remain.
    bit m_travel;
    int m_start, m_dist, m_elapsed;
    bit m_dir;
    int m_pos;
    int m_open_left, m_close_left;
    bit m_arrive;

    int cnt_open, cnt_close, cnt_arrive;
    logic prev_arrive = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int tl;
        tl = int'(target_lvl);
        if (rst) begin
            m_travel = 0; m_open_left = 0; m_close_left = 0;
            m_pos = 0; m_dir = 0; m_arrive = 0;
        end else begin
            m_arrive = 0;
            if (m_travel) begin
                m_elapsed++;
                m_pos = m_dir ? m_start + m_elapsed / T : m_start - m_elapsed / T;
                if (m_elapsed == m_dist * T) begin
                    m_travel = 0; m_open_left = D; m_arrive = 1;
                end
            end else if (m_open_left > 0) begin
                if (door_hold) m_open_left = D;
                else begin
                    m_open_left--;
                    if (m_open_left == 0) m_close_left = C;
                end
            end else if (m_close_left > 0) begin
                if (door_hold) begin
                    m_close_left = 0; m_open_left = D;
                end else m_close_left--;
            end else if (target_valid && tl < LEVELS) begin
                if (tl == m_pos) begin
                    m_open_left = D; m_arrive = 1;
                end else begin
                    m_travel = 1; m_start = m_pos; m_elapsed = 0;
                    m_dir = (tl > m_pos);
                    m_dist = m_dir ? tl - m_pos : m_pos - tl;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_divided);
        model_edge();
        #1;
        check("pos_lvl", 32'(pos_lvl), 32'(m_pos));
        check("moving", 32'(moving), 32'(m_travel));
        check("dir_up", 32'(dir_up), 32'(m_dir));
        check("door_open", 32'(door_open), 32'(m_open_left > 0));
        check("door_closing", 32'(door_closing), 32'(m_close_left > 0));
        check("arrive", 32'(arrive), 32'(m_arrive));
        check("busy", 32'(busy), 32'(m_travel || m_open_left > 0 || m_close_left > 0));
        check("arrive_pulse", 32'(arrive & prev_arrive), 32'(0));
        prev_arrive = arrive;
        if (door_open === 1'b1) cnt_open++;
        if (door_closing === 1'b1) cnt_close++;
        if (arrive === 1'b1) cnt_arrive++;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 100 && busy !== 1'b0; n++) step();
        check(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; target_valid = 1'b1; target_lvl = 2'd2; door_hold = 1'b0;
        m_travel = 0; m_open_left = 0; m_close_left = 0; m_pos = 0; m_dir = 0; m_arrive = 0;
        m_start = 0; m_dist = 0; m_elapsed = 0;

        // Reset held two cycles with a pending request.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_pos", 32'(pos_lvl), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_arrive", 32'(arrive), 32'(0));
        end

        // 0 -> 2 accepted at edge 0 (first edge after reset release).
        rst = 1'b0;
        step();
        check("up_moving_c1", 32'(moving), 32'(1));
        check("up_dir_c1", 32'(dir_up), 32'(1));
        for (int c = 2; c <= 17; c++) begin
            step();
            check("up_pos", 32'(pos_lvl), 32'((c >= 9) ? 2 : (c >= 5) ? 1 : 0));
            check("up_arrive", 32'(arrive), 32'(c == 9));
            check("up_door_open", 32'(door_open), 32'(c >= 9 && c <= 14));
            check("up_door_closing", 32'(door_closing), 32'(c >= 15 && c <= 16));
            check("up_busy", 32'(busy), 32'(c <= 16));
        end

        // Same-floor request (still pending at level 2) accepted at edge 17.
        cnt_open = 0; cnt_close = 0; cnt_arrive = 0;
        step();
        target_valid = 1'b0;
        check("same_arrive", 32'(arrive), 32'(1));
        check("same_door_open", 32'(door_open), 32'(1));
        check("same_moving", 32'(moving), 32'(0));
        for (int i = 0; i < 9; i++) step();
        check("same_open_cycles", 32'(cnt_open), 32'(D));
        check("same_close_cycles", 32'(cnt_close), 32'(C));
        check("same_arrive_count", 32'(cnt_arrive), 32'(1));
        check("same_pos", 32'(pos_lvl), 32'(2));

        // Door hold: pulse in 4th open cycle, then in 1st closing cycle.
        cnt_open = 0; cnt_close = 0; cnt_arrive = 0;
        target_valid = 1'b1; target_lvl = 2'd2;
        step();
        target_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        door_hold = 1'b1;
        step();
        door_hold = 1'b0;
        for (int n = 0; n < 40 && door_closing !== 1'b1; n++) step();
        check("hold_reach_close", 32'(door_closing), 32'(1));
        check("hold_open_before_close", 32'(cnt_open), 32'(10));
        door_hold = 1'b1;
        step();
        door_hold = 1'b0;
        check("hold_reopen", 32'(door_open), 32'(1));
        wait_idle("hold_idle");
        check("hold_open_cycles", 32'(cnt_open), 32'(16));
        check("hold_close_cycles", 32'(cnt_close), 32'(3));
        check("hold_arrive_count", 32'(cnt_arrive), 32'(1));

        // Go to level 3, then down to 0 while the target input changes mid-travel.
        target_valid = 1'b1; target_lvl = 2'd3;
        step();
        target_valid = 1'b0;
        wait_idle("to3_idle");
        check("to3_pos", 32'(pos_lvl), 32'(3));
        cnt_arrive = 0;
        target_valid = 1'b1; target_lvl = 2'd0;
        step();
        check("down_moving", 32'(moving), 32'(1));
        check("down_dir", 32'(dir_up), 32'(0));
        for (int j = 1; j <= 12; j++) begin
            if (j == 2) target_lvl = 2'd2;
            step();
            check("down_pos", 32'(pos_lvl), 32'(3 - j / T));
        end
        check("down_arrive", 32'(arrive), 32'(1));
        target_valid = 1'b0;
        wait_idle("down_idle");
        check("down_arrive_count", 32'(cnt_arrive), 32'(1));
        check("down_final_pos", 32'(pos_lvl), 32'(0));

        // Reset in the middle of a 0 -> 3 trip.
        cnt_arrive = 0;
        target_valid = 1'b1; target_lvl = 2'd3;
        step();
        target_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_pos", 32'(pos_lvl), 32'(1));
        check("mid_moving", 32'(moving), 32'(1));
        rst = 1'b1;
        step();
        check("mid_rst_pos", 32'(pos_lvl), 32'(0));
        check("mid_rst_moving", 32'(moving), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        step();
        check("mid_rst_stays_idle", 32'(busy), 32'(0));
        check("mid_rst_no_arrive", 32'(cnt_arrive), 32'(0));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            target_valid = ($urandom_range(0, 3) == 0);
            target_lvl   = LVL_W'($urandom_range(0, LEVELS - 1));
            door_hold    = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 1'b0; target_valid = 1'b0; door_hold = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
